// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_XOR  = 3'b100,
        OP_SLT  = 3'b101,
        OP_DIVU = 3'b110,
        OP_MUL  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic is_multicycle(input op_e op);
        return (op == OP_MUL) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// done is asserted during the last iteration; result/hi_nonzero then show its outcome.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             hi_nonzero
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic             busy;
    logic             is_div;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] m;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    // MUL: {hi,lo} starts as {0,a}; DIVU: hi is the partial remainder, lo shifts dividend out / quotient in.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        shifted = {hi, lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, m});
        diff    = shifted[WIDTH-1:0] - m;
        if (is_div) begin
            nxt_hi = ge ? diff : shifted[WIDTH-1:0];
            nxt_lo = {lo[WIDTH-2:0], ge};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end
        done       = busy && (cnt == CW'(WIDTH - 1));
        result     = nxt_lo;
        hi_nonzero = is_div ? (m == '0) : (nxt_hi != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            busy   <= 1'b0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
        end else if (start) begin
            cnt    <= '0;
            busy   <= 1'b1;
            is_div <= (op == OP_DIVU);
            hi     <= '0;
            lo     <= a;
            m      <= b;
        end else if (busy) begin
            hi  <= nxt_hi;
            lo  <= nxt_lo;
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, WIDTH-cycle iterative MUL/DIVU,
// valid/ready handshakes on both sides with registered result and flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    state_e           state;
    op_e              op;
    logic             accept;
    logic             multicycle;
    logic             md_start;
    logic             md_done;
    logic             md_hi_nonzero;
    logic [WIDTH-1:0] md_result;

    logic [WIDTH:0]          add_w;
    logic [WIDTH:0]          sub_w;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_carry;
    logic                    alu_ovf;

    always_comb begin
        op         = op_e'(alu_control);
        multicycle = is_multicycle(op);
        accept     = in_valid && in_ready;
        md_start   = accept && multicycle;
    end

    // Single-cycle datapath, evaluated straight from the request operands.
    always_comb begin
        sa        = $signed(a);
        sb        = $signed(b);
        add_w     = {1'b0, a} + {1'b0, b};
        sub_w     = {1'b0, a} - {1'b0, b};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SLT: alu_res = (sa < sb) ? WIDTH'(1) : '0;
            OP_ADD: begin
                alu_res   = add_w[WIDTH-1:0];
                alu_carry = add_w[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = sub_w[WIDTH-1:0];
                alu_carry = sub_w[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            default: alu_res = '0;
        endcase
    end

    alu_seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .op        (op),
        .a         (a),
        .b         (b),
        .done      (md_done),
        .result    (md_result),
        .hi_nonzero(md_hi_nonzero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (multicycle) begin
                            state <= CALC;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            carry     <= alu_carry;
                            overflow  <= alu_ovf;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                CALC: begin
                    if (md_done) begin
                        result    <= md_result;
                        zero      <= (md_result == '0);
                        carry     <= 1'b0;
                        overflow  <= md_hi_nonzero;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed corner cases plus random ops vs. an arithmetic model.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   alu_control;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         out_valid;
    logic         out_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .alu_control(alu_control),
        .result     (result),
        .zero       (zero),
        .carry      (carry),
        .overflow   (overflow),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the opcode rules evaluated with wide integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic c, output logic v, output int lat);
        longint sx;
        longint sy;
        longint s;
        logic [63:0] w;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        lat = 1;
        case (op)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: begin
                w = {32'b0, x} + {32'b0, y};
                r = w[31:0];
                c = w[32];
                s = sx + sy;
                v = (s != longint'($signed(s[31:0])));
            end
            3'd3: begin
                r = x - y;
                c = (x < y);
                s = sx - sy;
                v = (s != longint'($signed(s[31:0])));
            end
            3'd4: r = x ^ y;
            3'd5: r = (sx < sy) ? 32'd1 : 32'd0;
            3'd6: begin
                lat = W + 1;
                if (y == 0) begin
                    r = '1;
                    v = 1'b1;
                end else begin
                    r = x / y;
                end
            end
            default: begin
                lat = W + 1;
                w = {32'b0, x} * {32'b0, y};
                r = w[31:0];
                v = (w[63:32] != 0);
            end
        endcase
    endfunction

    // Issue one request, hold out_ready low for 'stall' cycles while poking the inputs, then hand off.
    task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv, input int stall);
        logic [31:0] er;
        logic        ec;
        logic        ev;
        int          elat;
        int          lat;
        logic [31:0] held;
        model(op, av, bv, er, ec, ev, elat);
        @(negedge clk);
        chk("in_ready_idle", {63'b0, in_ready}, 64'd1);
        in_valid    = 1'b1;
        alu_control = op;
        a           = av;
        b           = bv;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("latency op%0d", op), 64'(lat), 64'(elat));
        chk($sformatf("result op%0d %h,%h", op, av, bv), {32'b0, result}, {32'b0, er});
        chk("zero", {63'b0, zero}, {63'b0, (er == 0)});
        chk("carry", {63'b0, carry}, {63'b0, ec});
        chk("overflow", {63'b0, overflow}, {63'b0, ev});
        chk("in_ready_busy", {63'b0, in_ready}, 64'd0);
        for (int i = 0; i < stall; i++) begin
            in_valid    = 1'b1;
            alu_control = 3'($urandom_range(0, 7));
            a           = $urandom;
            b           = $urandom;
            @(posedge clk);
            #1;
            chk("stall_hold", {29'b0, out_valid, in_ready, zero, result}, {29'b0, 1'b1, 1'b0, (er == 0), er});
            chk("stall_flags", {62'b0, carry, overflow}, {62'b0, ec, ev});
        end
        held      = result;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("handoff_valid_low", {63'b0, out_valid}, 64'd0);
        chk("handoff_in_ready", {63'b0, in_ready}, 64'd1);
        chk("result_kept", {32'b0, result}, {32'b0, held});
    endtask

    initial begin
        logic        seen;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] corners [5];
        corners[0] = 32'h8000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h0000_0000;
        corners[3] = 32'h0000_0001;
        corners[4] = 32'h7FFF_FFFF;

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        alu_control = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {28'b0, out_valid, zero, carry, overflow, result}, 64'd0);
        chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;

        run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        chk("add_wrap", {61'b0, zero, carry, overflow}, {61'b0, 3'b110});
        run_op(3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        chk("slt_neg", {32'b0, result}, 64'd1);
        run_op(3'b111, 32'h0001_0000, 32'h0001_0000, 0);
        chk("mul_hi_only", {62'b0, zero, overflow}, {62'b0, 2'b11});
        run_op(3'b111, 32'd7, 32'd6, 0);
        chk("mul_7x6", {32'b0, result}, 64'd42);
        run_op(3'b110, 32'd100, 32'd7, 0);
        chk("divu_100_7", {32'b0, result}, 64'd14);
        run_op(3'b110, 32'd5, 32'd0, 0);
        chk("divu_by_zero", {31'b0, overflow, result}, {31'b0, 1'b1, 32'hFFFF_FFFF});
        run_op(3'b011, 32'h8000_0000, 32'h0000_0001, 10);
        chk("sub_ovf", {30'b0, overflow, carry, result}, {30'b0, 2'b10, 32'h7FFF_FFFF});

        // Abort a multiply partway through CALC.
        @(negedge clk);
        in_valid    = 1'b1;
        alu_control = 3'b111;
        a           = 32'h1234_5678;
        b           = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mul_accepted", {63'b0, in_ready}, 64'd0);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_outputs", {28'b0, out_valid, zero, carry, overflow, result}, 64'd0);
        chk("abort_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("no_valid_after_abort", {63'b0, seen}, 64'd0);
        run_op(3'b000, 32'h0000_F0F0, 32'h0000_0FF0, 0);
        chk("and_after_abort", {32'b0, result}, 64'h0000_00F0);

        for (int n = 0; n < 48; n++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = 32'($urandom_range(0, 15)); rb = 32'($urandom_range(0, 15)); end
                default: begin
                    ra = corners[$urandom_range(0, 4)];
                    rb = corners[$urandom_range(0, 4)];
                end
            endcase
            run_op(rop, ra, rb, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
